// File: rtl/tk1_spi_flash_reader_pkg.sv
// Shared definitions for the tk1 SPI flash reader: register map, STATUS bits,
// FSM states, transfer phases and command opcodes.
package tk1_spi_flash_reader_pkg;

  localparam logic [7:0] RegCtrl   = 8'h00;
  localparam logic [7:0] RegStatus = 8'h01;
  localparam logic [7:0] RegAddr   = 8'h02;
  localparam logic [7:0] RegLen    = 8'h03;
  localparam logic [7:0] RegRdata  = 8'h04;

  localparam int unsigned CtrlStartBit = 0;
  localparam int unsigned CtrlAbortBit = 1;

  localparam int unsigned StatBusyBit  = 0;
  localparam int unsigned StatEmptyBit = 1;
  localparam int unsigned StatFullBit  = 2;
  localparam int unsigned StatErrBit   = 3;

  localparam logic [7:0] CmdFastRead = 8'h0B;

  typedef enum logic [2:0] {
    StIdle, StSsOn, StLoad, StStart, StWait, StStore, StSsOff, StDone
  } state_e;

  typedef enum logic [2:0] {
    PhCmd, PhA2, PhA1, PhA0, PhDummy, PhData
  } phase_e;

  function automatic phase_e next_phase(input phase_e ph, input logic fast);
    case (ph)
      PhCmd:   return PhA2;
      PhA2:    return PhA1;
      PhA1:    return PhA0;
      PhA0:    return fast ? PhDummy : PhData;
      default: return PhData;
    endcase
  endfunction

endpackage

// File: rtl/tk1_spi_flash_fifo.sv
// Synchronous receive FIFO for the flash reader; first-word fall-through read port.
module tk1_spi_flash_fifo #(
  parameter int unsigned Depth = 16,
  parameter int unsigned Width = 8
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push_i,
  input  logic [Width-1:0] wdata_i,
  input  logic             pop_i,
  output logic [Width-1:0] rdata_o,
  output logic             empty_o,
  output logic             full_o
);
  localparam int unsigned PtrW = $clog2(Depth);
  localparam int unsigned LvlW = PtrW + 1;

  logic [Width-1:0] mem_q [Depth];
  logic [PtrW-1:0]  wr_ptr_q, rd_ptr_q;
  logic [LvlW-1:0]  level_q;
  logic             do_push, do_pop;

  assign empty_o = (level_q == '0);
  assign full_o  = (level_q == LvlW'(Depth));
  assign do_pop  = pop_i & ~empty_o;
  // A pop frees the head slot in the same cycle, so a push may proceed while full.
  assign do_push = push_i & (~full_o | do_pop);
  assign rdata_o = mem_q[rd_ptr_q];

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata_i;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + PtrW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
      if (do_push && !do_pop)      level_q <= level_q + LvlW'(1);
      else if (do_pop && !do_push) level_q <= level_q - LvlW'(1);
    end
  end

endmodule

// File: rtl/tk1_spi_flash_reader.sv
// Firmware-driven SPI flash bulk reader: sequences the tk1 SPI master and buffers rx bytes.
// Define TK1_SPI_FLASH_FAST_READ_EN for the 0x0B command with one dummy phase.
module tk1_spi_flash_reader
  import tk1_spi_flash_reader_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 16,
  parameter logic [7:0]  CMD_READ   = 8'h03,
  parameter logic [7:0]  DUMMY_BYTE = 8'h00
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        fw_app_mode,
  input  logic        cs,
  input  logic        we,
  input  logic [7:0]  address,
  input  logic [31:0] write_data,
  output logic [31:0] read_data,
  output logic        ready,
  output logic        spi_enable,
  output logic        spi_enable_vld,
  output logic [7:0]  spi_tx_data,
  output logic        spi_tx_data_vld,
  output logic        spi_start,
  input  logic [7:0]  spi_rx_data,
  input  logic        spi_ready,
  output logic        done_irq
);
`ifdef TK1_SPI_FLASH_FAST_READ_EN
  localparam logic FastRead = 1'b1;
`else
  localparam logic FastRead = 1'b0;
`endif
  localparam logic [7:0] Cmd = FastRead ? CmdFastRead : CMD_READ;

  state_e      state_q, state_d;
  phase_e      phase_q, phase_d;
  logic [15:0] cnt_q, cnt_d;
  logic [23:0] addr_q;
  logic [15:0] len_q;
  logic        err_q, abort_q, abort_d, skip_q, skip_d;

  logic        api_wr, api_rd, start_req, abort_req, abort_now, busy;
  logic        fifo_push, fifo_pop, pop_empty, fifo_empty, fifo_full;
  logic [7:0]  fifo_rdata, phase_byte;
  logic [3:0]  status;
  logic        unused_wdata;

  assign unused_wdata = ^write_data[31:24];
  assign ready     = cs;
  assign api_wr    = cs & we & ~fw_app_mode;
  assign api_rd    = cs & ~we & ~fw_app_mode;
  assign start_req = api_wr && (address == RegCtrl) && write_data[CtrlStartBit];
  assign abort_req = api_wr && (address == RegCtrl) && write_data[CtrlAbortBit];
  assign busy      = (state_q != StIdle) && (state_q != StDone);
  assign abort_now = abort_q | abort_req;
  assign fifo_pop  = api_rd && (address == RegRdata) && !fifo_empty;
  assign pop_empty = api_rd && (address == RegRdata) && fifo_empty;

  tk1_spi_flash_fifo #(
    .Depth (FIFO_DEPTH),
    .Width (8)
  ) u_fifo (
    .clk_i   (clk),
    .rst_ni  (reset_n),
    .push_i  (fifo_push),
    .wdata_i (spi_rx_data),
    .pop_i   (fifo_pop),
    .rdata_o (fifo_rdata),
    .empty_o (fifo_empty),
    .full_o  (fifo_full)
  );

  always_comb begin
    case (phase_q)
      PhCmd:   phase_byte = Cmd;
      PhA2:    phase_byte = addr_q[23:16];
      PhA1:    phase_byte = addr_q[15:8];
      PhA0:    phase_byte = addr_q[7:0];
      default: phase_byte = DUMMY_BYTE;
    endcase
  end

  always_comb begin
    state_d         = state_q;
    phase_d         = phase_q;
    cnt_d           = cnt_q;
    abort_d         = abort_q | (abort_req & busy);
    skip_d          = 1'b0;
    spi_enable      = 1'b0;
    spi_enable_vld  = 1'b0;
    spi_tx_data     = 8'h00;
    spi_tx_data_vld = 1'b0;
    spi_start       = 1'b0;
    done_irq        = 1'b0;
    fifo_push       = 1'b0;
    unique case (state_q)
      StIdle, StDone: begin
        done_irq = (state_q == StDone);
        state_d  = StIdle;
        abort_d  = 1'b0;
        if (start_req) begin
          phase_d = PhCmd;
          cnt_d   = len_q;
          state_d = (len_q == 16'd0) ? StDone : StSsOn;
        end
      end
      StSsOn: begin
        spi_enable     = 1'b1;
        spi_enable_vld = 1'b1;
        state_d        = StLoad;
      end
      StLoad: begin
        spi_tx_data     = phase_byte;
        spi_tx_data_vld = 1'b1;
        state_d         = abort_now ? StSsOff : StStart;
      end
      StStart: begin
        if (abort_now) begin
          state_d = StSsOff;
        end else begin
          spi_start = 1'b1;
          skip_d    = 1'b1;
          state_d   = StWait;
        end
      end
      StWait: begin
        // spi_ready may still show idle on the cycle right after the start strobe.
        if (!skip_q && spi_ready) state_d = StStore;
      end
      StStore: begin
        if (phase_q == PhData) begin
          if (!fifo_full) begin
            fifo_push = 1'b1;
            cnt_d     = cnt_q - 16'd1;
            state_d   = ((cnt_q == 16'd1) || abort_now) ? StSsOff : StLoad;
          end else if (abort_now) begin
            state_d = StSsOff;
          end
        end else begin
          phase_d = next_phase(phase_q, FastRead);
          state_d = abort_now ? StSsOff : StLoad;
        end
      end
      StSsOff: begin
        spi_enable_vld = 1'b1;
        state_d        = StDone;
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    status               = '0;
    status[StatBusyBit]  = busy;
    status[StatEmptyBit] = fifo_empty;
    status[StatFullBit]  = fifo_full;
    status[StatErrBit]   = err_q;
    read_data            = '0;
    if (api_rd) begin
      case (address)
        RegStatus: read_data = {28'h0, status};
        RegAddr:   read_data = {8'h0, addr_q};
        RegLen:    read_data = {16'h0, len_q};
        RegRdata:  read_data = fifo_empty ? 32'h0 : {24'h0, fifo_rdata};
        default:   read_data = '0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= StIdle;
      phase_q <= PhCmd;
      cnt_q   <= '0;
      addr_q  <= '0;
      len_q   <= '0;
      err_q   <= 1'b0;
      abort_q <= 1'b0;
      skip_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
      cnt_q   <= cnt_d;
      abort_q <= abort_d;
      skip_q  <= skip_d;
      if (api_wr && (address == RegAddr) && !busy) addr_q <= write_data[23:0];
      if (api_wr && (address == RegLen) && !busy)  len_q  <= write_data[15:0];
      if (api_wr && (address == RegStatus))            err_q <= 1'b0;
      else if ((start_req && busy) || pop_empty)       err_q <= 1'b1;
    end
  end

endmodule

// File: tb/tb_tk1_spi_flash_reader.sv
// Directed bench for tk1_spi_flash_reader with a behavioural SPI master that returns
// byte 0xC0+n for the n-th transfer after CS asserts.
module tb_tk1_spi_flash_reader;

`ifdef TK1_SPI_FLASH_FAST_READ_EN
  localparam int         HdrN   = 5;
  localparam logic [7:0] ExpCmd = 8'h0B;
`else
  localparam int         HdrN   = 4;
  localparam logic [7:0] ExpCmd = 8'h03;
`endif

  logic        clk = 1'b0, reset_n = 1'b0, fw_app_mode = 1'b0, cs = 1'b0, we = 1'b0;
  logic [7:0]  address = 8'h00;
  logic [31:0] write_data = 32'h0;
  logic [31:0] read_data;
  logic        ready, spi_enable, spi_enable_vld, spi_tx_data_vld, spi_start, done_irq;
  logic [7:0]  spi_tx_data, spi_rx_data;
  logic        spi_ready;

  always #5 clk = ~clk;

  tk1_spi_flash_reader dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .fw_app_mode     (fw_app_mode),
    .cs              (cs),
    .we              (we),
    .address         (address),
    .write_data      (write_data),
    .read_data       (read_data),
    .ready           (ready),
    .spi_enable      (spi_enable),
    .spi_enable_vld  (spi_enable_vld),
    .spi_tx_data     (spi_tx_data),
    .spi_tx_data_vld (spi_tx_data_vld),
    .spi_start       (spi_start),
    .spi_rx_data     (spi_rx_data),
    .spi_ready       (spi_ready),
    .done_irq        (done_irq)
  );

  // SPI master model: busy for 6 cycles after each start strobe.
  int busy_cnt, xfer_idx;
  always @(posedge clk) begin
    if (!reset_n) begin
      spi_ready   <= 1'b1;
      spi_rx_data <= 8'h00;
      busy_cnt    <= 0;
      xfer_idx    <= 0;
    end else begin
      if (spi_enable_vld && spi_enable) xfer_idx <= 0;
      if (spi_start) begin
        spi_ready <= 1'b0;
        busy_cnt  <= 6;
      end else if (busy_cnt > 0) begin
        busy_cnt <= busy_cnt - 1;
        if (busy_cnt == 1) begin
          spi_ready   <= 1'b1;
          spi_rx_data <= 8'(8'hC0 + xfer_idx);
          xfer_idx    <= xfer_idx + 1;
        end
      end
    end
  end

  logic [7:0] tx_log[$];
  logic       en_log[$];
  int         done_cnt = 0, start_cnt = 0;
  always @(posedge clk) begin
    if (reset_n) begin
      if (spi_tx_data_vld) tx_log.push_back(spi_tx_data);
      if (spi_enable_vld)  en_log.push_back(spi_enable);
      if (done_irq)        done_cnt  <= done_cnt + 1;
      if (spi_start)       start_cnt <= start_cnt + 1;
    end
  end

  int n_checks = 0, n_pass = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic wr(input logic [7:0] a, input logic [31:0] d);
    @(negedge clk);
    cs = 1'b1; we = 1'b1; address = a; write_data = d;
    @(negedge clk);
    cs = 1'b0; we = 1'b0;
  endtask

  task automatic rd(input logic [7:0] a, output logic [31:0] d);
    @(negedge clk);
    cs = 1'b1; we = 1'b0; address = a;
    #1 d = read_data;
    @(negedge clk);
    cs = 1'b0;
  endtask

  task automatic rd_check(input string name, input logic [7:0] a, input logic [31:0] exp);
    logic [31:0] d;
    rd(a, d);
    check(name, d, exp);
  endtask

  task automatic wait_done(input int base, input int budget);
    int i = 0;
    while (done_cnt == base && i < budget) begin
      @(negedge clk);
      i++;
    end
    repeat (3) @(negedge clk);
    check("done_irq pulse count", 32'(done_cnt - base), 32'd1);
  endtask

  task automatic wait_starts(input int target);
    int i = 0;
    while (start_cnt < target && i < 2000) begin
      @(negedge clk);
      i++;
    end
    check("spi_start count reached", 32'(start_cnt >= target), 32'd1);
  endtask

  typedef struct {
    logic        is_wr;
    logic [7:0]  addr;
    logic [31:0] data;
    logic [31:0] exp;
    string       name;
  } vec_t;

  vec_t vecs[10];

  initial begin
    int tb, eb, db, sb;
    logic [31:0] d;

    vecs[0] = '{1'b1, 8'h02, 32'hFF012345, 32'h0,        "wr addr"};
    vecs[1] = '{1'b0, 8'h02, 32'h0,        32'h00012345, "addr masked to 24b"};
    vecs[2] = '{1'b1, 8'h03, 32'hFFFF0004, 32'h0,        "wr len"};
    vecs[3] = '{1'b0, 8'h03, 32'h0,        32'h00000004, "len masked to 16b"};
    vecs[4] = '{1'b0, 8'h01, 32'h0,        32'h00000002, "status idle empty"};
    vecs[5] = '{1'b0, 8'h04, 32'h0,        32'h00000000, "rdata on empty"};
    vecs[6] = '{1'b0, 8'h01, 32'h0,        32'h0000000A, "status err after empty pop"};
    vecs[7] = '{1'b1, 8'h01, 32'h0,        32'h0,        "wr status clears err"};
    vecs[8] = '{1'b0, 8'h01, 32'h0,        32'h00000002, "status err cleared"};
    vecs[9] = '{1'b0, 8'h00, 32'h0,        32'h00000000, "ctrl reads zero"};

    repeat (3) @(negedge clk);
    check("reset outputs", {18'h0, ready, spi_enable, spi_enable_vld, spi_tx_data,
                            spi_tx_data_vld, spi_start, done_irq}, 32'h0);
    reset_n = 1'b1;
    @(negedge clk);
    check("read_data idle", read_data, 32'h0);
    cs = 1'b1; address = 8'h7F;
    #1 check("ready follows cs", 32'(ready), 32'd1);
    @(negedge clk);
    cs = 1'b0;

    foreach (vecs[i]) begin
      if (vecs[i].is_wr) wr(vecs[i].addr, vecs[i].data);
      else begin
        rd(vecs[i].addr, d);
        check(vecs[i].name, d, vecs[i].exp);
      end
    end

    // Basic 4-byte read.
    tb = tx_log.size(); eb = en_log.size(); db = done_cnt;
    wr(8'h00, 32'h1);
    wait_done(db, 1000);
    check("tx count len4", 32'(tx_log.size() - tb), 32'(HdrN + 4));
    for (int i = 0; i < HdrN + 4; i++) begin
      logic [7:0] e;
      e = (i == 0) ? ExpCmd : (i == 1) ? 8'h01 : (i == 2) ? 8'h23 : (i == 3) ? 8'h45 : 8'h00;
      if (tb + i < tx_log.size()) check($sformatf("tx byte %0d", i), 32'(tx_log[tb + i]), 32'(e));
    end
    check("cs strobes", 32'(en_log.size() - eb), 32'd2);
    if (en_log.size() >= eb + 2) check("cs on then off", {30'h0, en_log[eb], en_log[eb + 1]}, 32'h2);
    for (int i = 0; i < 4; i++) rd_check($sformatf("len4 data %0d", i), 8'h04, 32'(8'hC0 + HdrN + i));
    rd_check("status after drain", 8'h01, 32'h2);

    // LEN=0: done the cycle after start, no SPI traffic.
    wr(8'h03, 32'h0);
    tb = tx_log.size(); eb = en_log.size(); db = done_cnt;
    wr(8'h00, 32'h1);
    check("len0 done next cycle", 32'(done_irq), 32'd1);
    repeat (3) @(negedge clk);
    check("len0 no tx/cs", 32'((tx_log.size() - tb) + (en_log.size() - eb)), 32'd0);
    check("len0 single done", 32'(done_cnt - db), 32'd1);

    // LEN=20 with no pops: stall on full FIFO with CS held.
    wr(8'h03, 32'd20);
    tb = tx_log.size(); eb = en_log.size(); db = done_cnt;
    wr(8'h00, 32'h1);
    repeat (400) @(negedge clk);
    rd_check("status full stall", 8'h01, 32'h5);
    check("stall tx count", 32'(tx_log.size() - tb), 32'(HdrN + 17));
    check("stall cs held", 32'(en_log.size() - eb), 32'd1);
    check("stall no done", 32'(done_cnt - db), 32'd0);
    for (int i = 0; i < 4; i++) rd_check($sformatf("stall pop %0d", i), 8'h04, 32'(8'hC0 + HdrN + i));
    wait_done(db, 1000);
    check("len20 tx count", 32'(tx_log.size() - tb), 32'(HdrN + 20));
    check("len20 cs off", 32'(en_log.size() - eb), 32'd2);
    for (int i = 4; i < 20; i++) rd_check($sformatf("len20 data %0d", i), 8'h04, 32'(8'hC0 + HdrN + i));
    rd_check("len20 drained", 8'h01, 32'h2);

    // Abort during the second data byte's WAIT after popping the first.
    wr(8'h03, 32'd4);
    tb = tx_log.size(); eb = en_log.size(); db = done_cnt; sb = start_cnt;
    wr(8'h00, 32'h1);
    wait_starts(sb + HdrN + 2);
    rd_check("abort first data", 8'h04, 32'(8'hC0 + HdrN));
    wr(8'h00, 32'h2);
    wait_done(db, 1000);
    check("abort tx count", 32'(tx_log.size() - tb), 32'(HdrN + 2));
    check("abort cs strobes", 32'(en_log.size() - eb), 32'd2);
    rd_check("abort status one left", 8'h01, 32'h0);
    rd_check("abort second data", 8'h04, 32'(8'hC0 + HdrN + 1));
    rd_check("abort drained", 8'h01, 32'h2);

    // start while busy is ignored and flags err.
    tb = tx_log.size(); db = done_cnt;
    wr(8'h00, 32'h1);
    wr(8'h00, 32'h1);
    rd_check("busy start err", 8'h01, 32'hB);
    wait_done(db, 1000);
    check("busy start tx count", 32'(tx_log.size() - tb), 32'(HdrN + 4));
    for (int i = 0; i < 4; i++) rd(8'h04, d);
    wr(8'h01, 32'h0);
    rd_check("busy err cleared", 8'h01, 32'h2);

    // App mode blocks the API.
    @(negedge clk);
    fw_app_mode = 1'b1;
    wr(8'h02, 32'h00ABCDEF);
    rd_check("app mode read zero", 8'h02, 32'h0);
    fw_app_mode = 1'b0;
    rd_check("app mode write ignored", 8'h02, 32'h00012345);

    // Synchronous reset mid-read.
    wr(8'h00, 32'h1);
    check("ss_on strobe", {30'h0, spi_enable, spi_enable_vld}, 32'h3);
    reset_n = 1'b0;
    @(negedge clk);
    check("reset mid-read outputs", {18'h0, ready, spi_enable, spi_enable_vld, spi_tx_data,
                                     spi_tx_data_vld, spi_start, done_irq}, 32'h0);
    reset_n = 1'b1;
    rd_check("post reset status", 8'h01, 32'h2);
    rd_check("post reset addr", 8'h02, 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
